// File: rtl/clause_mem_arbiter.sv
// Round-robin burst arbiter for the single port of the BCP clause data memory.
// Optional macro CLAUSE_ARB_INIT_PRIORITY_EN: requester 0 always wins IDLE arbitration when requesting.
module clause_mem_arbiter #(
    parameter int N_REQ     = 3,
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 16,
    localparam int ID_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ-1:0]          last,
    input  logic [N_REQ*ADDR_W-1:0]   addr_in,
    input  logic [N_REQ-1:0]          we_in,
    input  logic [N_REQ*DATA_W-1:0]   wdata_in,
    output logic [N_REQ-1:0]          gnt,
    output logic                      mem_en,
    output logic                      mem_we,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wdata,
    output logic                      rvalid,
    output logic [ID_W-1:0]           rvalid_id,
    output logic                      busy
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t            state_reg, state_next;
    logic [ID_W-1:0]   owner_reg, owner_next;
    logic [ID_W-1:0]   rr_ptr_reg, rr_ptr_next;
    logic [CNT_W-1:0]  beat_cnt_reg, beat_cnt_next;
    logic              rvalid_reg;
    logic [ID_W-1:0]   rvalid_id_reg;

    logic [ID_W-1:0]   arb_owner;
    logic [ID_W-1:0]   owner_inc;
    logic [CNT_W-1:0]  beat_cnt_inc;

    logic [ADDR_W-1:0] addr_arr  [N_REQ];
    logic [DATA_W-1:0] wdata_arr [N_REQ];

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
        assign addr_arr[gi]  = addr_in[gi*ADDR_W +: ADDR_W];
        assign wdata_arr[gi] = wdata_in[gi*DATA_W +: DATA_W];
    end

    assign owner_inc    = (owner_reg == ID_W'(N_REQ - 1)) ? '0 : owner_reg + 1'b1;
    assign beat_cnt_inc = beat_cnt_reg + 1'b1;

    // First requester at or after rr_ptr, wrapping around.
    always_comb begin
        int  cand;
        logic found;
        cand      = 0;
        found     = 1'b0;
        arb_owner = rr_ptr_reg;
        for (int i = 0; i < N_REQ; i++) begin
            cand = int'(rr_ptr_reg) + i;
            if (cand >= N_REQ)
                cand = cand - N_REQ;
            if (!found && req[cand]) begin
                arb_owner = ID_W'(cand);
                found     = 1'b1;
            end
        end
`ifdef CLAUSE_ARB_INIT_PRIORITY_EN
        if (req[0])
            arb_owner = '0;
`else
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            owner_reg     <= '0;
            rr_ptr_reg    <= '0;
            beat_cnt_reg  <= '0;
            rvalid_reg    <= 1'b0;
            rvalid_id_reg <= '0;
        end else begin
            state_reg    <= state_next;
            owner_reg    <= owner_next;
            rr_ptr_reg   <= rr_ptr_next;
            beat_cnt_reg <= beat_cnt_next;
            rvalid_reg   <= mem_en & ~mem_we;
            if (mem_en && !mem_we)
                rvalid_id_reg <= owner_reg;
        end
    end

    always_comb begin
        state_next    = state_reg;
        owner_next    = owner_reg;
        rr_ptr_next   = rr_ptr_reg;
        beat_cnt_next = beat_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (|req) begin
                    state_next = GRANT;
                    owner_next = arb_owner;
                end
            end
            GRANT: begin
                // A dropped request ends the burst regardless of last.
                if (!req[owner_reg] || last[owner_reg] ||
                    beat_cnt_inc == CNT_W'(MAX_BURST)) begin
                    state_next    = IDLE;
                    rr_ptr_next   = owner_inc;
                    beat_cnt_next = '0;
                end else begin
                    beat_cnt_next = beat_cnt_inc;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        gnt       = '0;
        busy      = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (state_reg == GRANT) begin
            gnt[owner_reg] = 1'b1;
            busy           = 1'b1;
            if (req[owner_reg]) begin
                mem_en    = 1'b1;
                mem_we    = we_in[owner_reg];
                mem_addr  = addr_arr[owner_reg];
                mem_wdata = wdata_arr[owner_reg];
            end
        end
    end

    assign rvalid    = rvalid_reg;
    assign rvalid_id = rvalid_id_reg;

endmodule

// File: tb/tb_clause_mem_arbiter.sv
// Directed testbench for clause_mem_arbiter with default parameters (3 requesters, MAX_BURST=16).
module tb_clause_mem_arbiter;

    localparam int N_REQ     = 3;
    localparam int ADDR_W    = 8;
    localparam int DATA_W    = 32;
    localparam int MAX_BURST = 16;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [N_REQ-1:0]        req, last, we_in;
    logic [N_REQ*ADDR_W-1:0] addr_in;
    logic [N_REQ*DATA_W-1:0] wdata_in;
    logic [N_REQ-1:0]        gnt;
    logic                    mem_en, mem_we, rvalid, busy;
    logic [ADDR_W-1:0]       mem_addr;
    logic [DATA_W-1:0]       mem_wdata;
    logic [1:0]              rvalid_id;

    int tests = 0;
    int fails = 0;

    clause_mem_arbiter #(
        .N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .last(last), .addr_in(addr_in),
        .we_in(we_in), .wdata_in(wdata_in), .gnt(gnt), .mem_en(mem_en),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .rvalid(rvalid), .rvalid_id(rvalid_id), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic set_slice(input int i, input logic [ADDR_W-1:0] a, input logic w,
                             input logic [DATA_W-1:0] d);
        addr_in[i*ADDR_W +: ADDR_W]  = a;
        we_in[i]                     = w;
        wdata_in[i*DATA_W +: DATA_W] = d;
    endtask

    task automatic clear_inputs();
        req = '0; last = '0; we_in = '0; addr_in = '0; wdata_in = '0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        clear_inputs();
        next_cycle();
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 3'b111; last = 3'b000; we_in = 3'b111;
        addr_in = '1; wdata_in = '1;
        next_cycle();
        next_cycle();
        settle();
        tests++; if (gnt !== 3'b000) begin fails++; $display("FAIL reset_gnt: got %b expected 000", gnt); end
        tests++; if (mem_en !== 1'b0) begin fails++; $display("FAIL reset_mem_en: got %b expected 0", mem_en); end
        tests++; if (mem_we !== 1'b0) begin fails++; $display("FAIL reset_mem_we: got %b expected 0", mem_we); end
        tests++; if (mem_addr !== 8'h00) begin fails++; $display("FAIL reset_mem_addr: got %h expected 00", mem_addr); end
        tests++; if (mem_wdata !== 32'h0) begin fails++; $display("FAIL reset_mem_wdata: got %h expected 0", mem_wdata); end
        tests++; if (rvalid !== 1'b0) begin fails++; $display("FAIL reset_rvalid: got %b expected 0", rvalid); end
        tests++; if (rvalid_id !== 2'd0) begin fails++; $display("FAIL reset_rvalid_id: got %0d expected 0", rvalid_id); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
        $display("[TB] reset: outputs checked while rst held");
    endtask

    task automatic test_single_requester();
        logic [2:0] exp_gnt [6] = '{3'b000, 3'b010, 3'b010, 3'b010, 3'b000, 3'b000};
        logic       exp_en  [6] = '{0, 1, 1, 1, 0, 0};
        logic [7:0] exp_adr [6] = '{8'h00, 8'h05, 8'h06, 8'h07, 8'h00, 8'h00};
        logic       exp_rv  [6] = '{0, 0, 1, 1, 1, 0};
        logic [7:0] drv_adr [4] = '{8'h05, 8'h05, 8'h06, 8'h07};
        apply_reset();
        for (int c = 0; c < 6; c++) begin
            if (c > 0) next_cycle();
            if (c < 4) begin
                req = 3'b010;
                set_slice(1, drv_adr[c], 1'b0, 32'h0);
                last = (c == 3) ? 3'b010 : 3'b000;
            end else begin
                req = 3'b000; last = 3'b000;
            end
            settle();
            tests++; if (gnt !== exp_gnt[c]) begin fails++; $display("FAIL single_gnt c%0d: got %b expected %b", c, gnt, exp_gnt[c]); end
            tests++; if (mem_en !== exp_en[c]) begin fails++; $display("FAIL single_mem_en c%0d: got %b expected %b", c, mem_en, exp_en[c]); end
            tests++; if (mem_addr !== exp_adr[c]) begin fails++; $display("FAIL single_mem_addr c%0d: got %h expected %h", c, mem_addr, exp_adr[c]); end
            tests++; if (rvalid !== exp_rv[c]) begin fails++; $display("FAIL single_rvalid c%0d: got %b expected %b", c, rvalid, exp_rv[c]); end
            if (exp_rv[c]) begin
                tests++; if (rvalid_id !== 2'd1) begin fails++; $display("FAIL single_rvalid_id c%0d: got %0d expected 1", c, rvalid_id); end
            end
            $display("[TB] single c%0d: gnt=%b en=%b addr=%h rvalid=%b id=%0d", c, gnt, mem_en, mem_addr, rvalid, rvalid_id);
        end
    endtask

    task automatic test_contention();
        logic [2:0] exp_gnt;
        logic [7:0] exp_adr;
        int         own;
        apply_reset();
        set_slice(0, 8'h10, 1'b0, 32'h0);
        set_slice(1, 8'h20, 1'b0, 32'h0);
        set_slice(2, 8'h30, 1'b0, 32'h0);
        req = 3'b111;
        settle();
        tests++; if (gnt !== 3'b000) begin fails++; $display("FAIL contention_start_gnt: got %b expected 000", gnt); end
        for (int g = 0; g < 4; g++) begin
            own     = g % 3;
            exp_gnt = 3'b001 << own;
            exp_adr = 8'(8'h10 * (own + 1));
            for (int b = 0; b < MAX_BURST; b++) begin
                next_cycle();
                settle();
                tests++; if (gnt !== exp_gnt || mem_en !== 1'b1) begin fails++; $display("FAIL contention_beat g%0d b%0d: got gnt=%b en=%b expected gnt=%b en=1", g, b, gnt, mem_en, exp_gnt); end
                tests++; if (mem_addr !== exp_adr) begin fails++; $display("FAIL contention_addr g%0d b%0d: got %h expected %h", g, b, mem_addr, exp_adr); end
            end
            next_cycle();
            if (g == 3) req = 3'b000;
            settle();
            tests++; if (gnt !== 3'b000 || mem_en !== 1'b0) begin fails++; $display("FAIL contention_bubble g%0d: got gnt=%b en=%b expected gnt=000 en=0", g, gnt, mem_en); end
            $display("[TB] contention grant %0d: owner %0d, %0d beats then bubble", g, own, MAX_BURST);
        end
    endtask

    task automatic test_early_release();
        int pulses = 0;
        apply_reset();
        set_slice(2, 8'h40, 1'b0, 32'h0);
        req = 3'b100;
        settle();
        if (mem_en) pulses++;
        for (int c = 1; c <= 6; c++) begin
            next_cycle();
            if (c == 5) req = 3'b000;
            settle();
            if (mem_en) pulses++;
            if (c <= 5) begin
                tests++; if (gnt !== 3'b100) begin fails++; $display("FAIL early_gnt c%0d: got %b expected 100", c, gnt); end
            end else begin
                tests++; if (busy !== 1'b0 || gnt !== 3'b000) begin fails++; $display("FAIL early_idle c%0d: got busy=%b gnt=%b expected busy=0 gnt=000", c, busy, gnt); end
            end
        end
        tests++; if (pulses != 4) begin fails++; $display("FAIL early_pulses: got %0d expected 4", pulses); end
        req = 3'b011;
        next_cycle();
        settle();
        tests++; if (gnt !== 3'b001) begin fails++; $display("FAIL early_rr_wrap: got %b expected 001", gnt); end
        req = 3'b000;
        next_cycle();
        $display("[TB] early release: %0d mem_en pulses, next grant %b", pulses, gnt);
    endtask

    task automatic test_writes();
        apply_reset();
        req = 3'b001;
        set_slice(0, 8'h00, 1'b1, 32'hA0);
        settle();
        for (int c = 1; c <= 6; c++) begin
            next_cycle();
            if (c <= 4) begin
                set_slice(0, 8'(c - 1), 1'b1, 32'hA0 + 32'(c - 1));
                last = (c == 4) ? 3'b001 : 3'b000;
            end else begin
                req = 3'b000; last = 3'b000; we_in = 3'b000;
            end
            settle();
            if (c <= 4) begin
                tests++; if (mem_en !== 1'b1 || mem_we !== 1'b1) begin fails++; $display("FAIL write_en_we c%0d: got en=%b we=%b expected 1/1", c, mem_en, mem_we); end
                tests++; if (mem_addr !== 8'(c - 1)) begin fails++; $display("FAIL write_addr c%0d: got %h expected %h", c, mem_addr, 8'(c - 1)); end
                tests++; if (mem_wdata !== 32'hA0 + 32'(c - 1)) begin fails++; $display("FAIL write_data c%0d: got %h expected %h", c, mem_wdata, 32'hA0 + 32'(c - 1)); end
            end else begin
                tests++; if (gnt !== 3'b000) begin fails++; $display("FAIL write_end_gnt c%0d: got %b expected 000", c, gnt); end
            end
            tests++; if (rvalid !== 1'b0) begin fails++; $display("FAIL write_rvalid c%0d: got %b expected 0", c, rvalid); end
            $display("[TB] write c%0d: en=%b we=%b addr=%h data=%h rvalid=%b", c, mem_en, mem_we, mem_addr, mem_wdata, rvalid);
        end
    endtask

    // Entered with rr_ptr=1 left by the write burst of requester 0.
    task automatic test_reset_mid_burst();
        req = 3'b010;
        set_slice(1, 8'h50, 1'b0, 32'h0);
        settle();
        for (int c = 1; c <= 5; c++) begin
            next_cycle();
            set_slice(1, 8'h50 + 8'(c - 1), 1'b0, 32'h0);
            settle();
        end
        tests++; if (mem_en !== 1'b1 || gnt !== 3'b010 || rvalid !== 1'b1) begin fails++; $display("FAIL midrst_pre: got en=%b gnt=%b rvalid=%b expected 1/010/1", mem_en, gnt, rvalid); end
        rst = 1'b1;
        #1;
        tests++; if (gnt !== 3'b000 || busy !== 1'b0) begin fails++; $display("FAIL midrst_gnt: got gnt=%b busy=%b expected 000/0", gnt, busy); end
        tests++; if (mem_en !== 1'b0 || mem_addr !== 8'h00) begin fails++; $display("FAIL midrst_mem: got en=%b addr=%h expected 0/00", mem_en, mem_addr); end
        tests++; if (rvalid !== 1'b0) begin fails++; $display("FAIL midrst_rvalid_same: got %b expected 0", rvalid); end
        next_cycle();
        rst = 1'b0;
        req = 3'b011;
        settle();
        tests++; if (rvalid !== 1'b0) begin fails++; $display("FAIL midrst_rvalid_next: got %b expected 0", rvalid); end
        next_cycle();
        settle();
        tests++; if (gnt !== 3'b001) begin fails++; $display("FAIL midrst_regrant: got %b expected 001", gnt); end
        req = 3'b000;
        $display("[TB] reset mid-burst: regrant %b", gnt);
    endtask

    // Entered with rr_ptr=1 (owner 0 just released).
    task automatic test_init_priority();
        logic [2:0] exp_gnt;
`ifdef CLAUSE_ARB_INIT_PRIORITY_EN
        exp_gnt = 3'b001;
`else
        exp_gnt = 3'b010;
`endif
        next_cycle();
        req = 3'b011;
        settle();
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL prio_idle: got busy=%b expected 0", busy); end
        next_cycle();
        settle();
        tests++; if (gnt !== exp_gnt) begin fails++; $display("FAIL prio_gnt: got %b expected %b", gnt, exp_gnt); end
        req = 3'b000;
        next_cycle();
        $display("[TB] priority arbitration: gnt=%b", gnt);
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        test_reset();
        test_single_requester();
        test_contention();
        test_early_release();
        test_writes();
        test_reset_mid_burst();
        test_init_priority();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/clause_mem_arbiter.md
# clause_mem_arbiter

Round-robin arbiter for the single port of the BCP engine clause data memory. It shares that port between the initial loader, the BCP clause scanner and the learned-clause writer. Each requester gets bursts of back-to-back accesses. Read data is tagged with the owner's ID one cycle after each read beat. The block sits between the requesters and the clause memory's `en/we/addr/wdata` pins.

## Interface
- N_REQ, 3, number of requesters; index 0 is the initial loader
- ADDR_W, 8, clause address width (set to `clause_num_log` at instantiation)
- DATA_W, 32, memory write data width
- MAX_BURST, 16, maximum beats per grant, ≥1
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req  in  N_REQ  per-requester access request; held high while beats are wanted
- last  in  N_REQ  marks the current beat as the final beat of the burst
- addr_in  in  N_REQ*ADDR_W  per-requester address, requester i at bits [i*ADDR_W +: ADDR_W]
- we_in  in  N_REQ  per-requester write enable
- wdata_in  in  N_REQ*DATA_W  per-requester write data, same packing as addr_in
- gnt  out  N_REQ  one-hot grant, registered
- mem_en  out  1  memory enable
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- rvalid  out  1  read data on memory output is valid this cycle
- rvalid_id  out  $clog2(N_REQ)  owner of the read data
- busy  out  1  high while in GRANT

## Operation
- States:
  - IDLE: gnt=0.
  - GRANT: gnt[owner]=1.
- IDLE → GRANT when any req is high. The owner is the first requester with req high, searching from rr_ptr upward with wrap (rr_ptr, rr_ptr+1, …, N_REQ-1, 0, …).
- A beat is a GRANT cycle with req[owner]=1. On a beat:
  - mem_en=1.
  - mem_addr, mem_we and mem_wdata are muxed from the owner's slices.
  - beat_cnt increments.
- mem_en, mem_we, mem_addr and mem_wdata are combinational from state, owner and inputs. With no beat: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
- GRANT → IDLE on any of:
  - a beat with last[owner]=1;
  - a beat that makes beat_cnt equal MAX_BURST;
  - req[owner]=0 (no beat this cycle).
- On the GRANT → IDLE transition: rr_ptr ← owner+1 (wraps N_REQ-1 → 0), beat_cnt ← 0.
- GRANT otherwise stays, with the same owner.
- Read beats (mem_en=1, mem_we=0) set rvalid=1 and rvalid_id=owner on the next cycle. The memory has 1-cycle read latency. Write beats produce no rvalid.
- Requests from non-owners are ignored until IDLE. There is no preemption.
- last from a non-owner has no effect.
- Reset mid-burst aborts immediately. All outputs go to 0, as do rr_ptr, owner and beat_cnt. A pending rvalid is dropped.

## Timing
- Reset values: gnt=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, rvalid=0, rvalid_id=0, busy=0.
- Request to first beat:
  - req rises in cycle t while IDLE: gnt is high in t+1.
  - The first memory access is in t+1 if req is still high.
- Each burst ends in IDLE for at least one cycle, which is the arbitration bubble. Maximum port utilisation is MAX_BURST/(MAX_BURST+1).
- Read latency: beat in cycle t, rvalid/rvalid_id in t+1, aligned with the memory's registered output.
- Requesters must hold addr_in, we_in and wdata_in stable in any cycle where req=1 and gnt=1.
- rvalid is strictly one cycle after the read beat and is independent of the owner change in that cycle.

## Configuration
- CLAUSE_ARB_INIT_PRIORITY_EN:
  - Defined: requester 0 wins any IDLE arbitration in which req[0]=1, regardless of rr_ptr. All other choices use round-robin as normal, and rr_ptr updates identically.
  - Undefined: pure round-robin for all requesters.

## Test plan
- Single requester:
  - req[1]=1 in cycle 0, addr 0x05/0x06/0x07 reads, last on the third beat.
  - Expect gnt=3'b010 in cycles 1–3, mem_addr 5/6/7 in cycles 1–3, rvalid with id 1 in cycles 2–4, gnt=0 in cycle 4.
- Contention: req=3'b111 held, no last, MAX_BURST=16.
  - Grants in order 0,1,2,0, each 16 beats, with one idle cycle between grants.
- Early release: owner 2 drops req after 4 beats.
  - Expect IDLE in the next cycle, rr_ptr=0, and 4 mem_en pulses only.
- Writes: requester 0 writes addr 0–3 with data 0xA0–0xA3.
  - Expect mem_we=1 on each beat, correct data, and rvalid never asserted.
- Reset mid-burst: assert rst on beat 5 of requester 1.
  - Expect all outputs 0 in the same cycle and rvalid=0 in the next.
  - After release with req=3'b011, grant goes to 0 (rr_ptr reset).
- With CLAUSE_ARB_INIT_PRIORITY_EN: rr_ptr=1 and req=3'b011 in IDLE.
  - Expect gnt=3'b001.
  - Without the macro, expect gnt=3'b010.
